// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end for a single APB master: grants one
// request at a time, issues it to the master, and reports completion.
module apb_req_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             i_PCLK,
  input  logic             i_PRESETn,
  input  logic [1:0]       i_req,
  input  logic             i_rw0,
  input  logic             i_rw1,
  input  logic [WIDTH-1:0] i_addr0,
  input  logic [WIDTH-1:0] i_addr1,
  input  logic [WIDTH-1:0] i_wdata0,
  input  logic [WIDTH-1:0] i_wdata1,
  output logic [1:0]       o_gnt,
  output logic [1:0]       o_done,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_busy,
  output logic             o_transfer,
  output logic             o_READ_WRITE,
  output logic [WIDTH-1:0] o_apb_write_paddr,
  output logic [WIDTH-1:0] o_apb_read_paddr,
  output logic [WIDTH-1:0] o_apb_write_data,
  input  logic             i_PSEL1,
  input  logic             i_PENABLE,
  input  logic             i_PREADY,
  input  logic [WIDTH-1:0] i_prdata,
  output logic [1:0]       o_dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             rw_q, rw_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             win1;
  logic             bus_complete;

  // Handshake: a requester raises i_req[n] with its command fields valid and
  // holds it until o_done[n]; the command is consumed on the granting edge.
  always_comb begin
    win1         = i_req[1] & (~i_req[0] | ~last_q);
    bus_complete = i_PSEL1 & i_PENABLE & i_PREADY;

    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          state_d = ST_ISSUE;
          gnt_d   = win1 ? 2'b10 : 2'b01;
          rw_d    = win1 ? i_rw1 : i_rw0;
          addr_d  = win1 ? i_addr1 : i_addr0;
          wdata_d = win1 ? i_wdata1 : i_wdata0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus_complete) begin
          state_d = ST_DONE;
          last_d  = gnt_q[1];
          if (!rw_q) begin
            rdata_d = i_prdata;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // last_q resets to requester 1 so requester 0 wins the first contention.
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_gnt             = gnt_q;
  assign o_done            = (state_q == ST_DONE) ? gnt_q : 2'b00;
  assign o_busy            = (state_q != ST_IDLE);
  assign o_transfer        = (state_q == ST_ISSUE);
  assign o_READ_WRITE      = rw_q;
  assign o_apb_write_paddr = addr_q;
  assign o_apb_read_paddr  = addr_q;
  assign o_apb_write_data  = wdata_q;
  assign o_rdata           = rdata_q;
  assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: APB master/slave model, directed vector table,
// contention and reset sequences, then randomized traffic against a model.
module tb_apb_req_arbiter;

  logic       i_PCLK = 1'b0;
  logic       i_PRESETn;
  logic [1:0] i_req;
  logic       i_rw0, i_rw1;
  logic [7:0] i_addr0, i_addr1, i_wdata0, i_wdata1;
  logic [1:0] o_gnt, o_done;
  logic [7:0] o_rdata;
  logic       o_busy, o_transfer, o_READ_WRITE;
  logic [7:0] o_apb_write_paddr, o_apb_read_paddr, o_apb_write_data;
  logic       i_PSEL1, i_PENABLE, i_PREADY;
  logic [7:0] i_prdata;
  logic [1:0] o_dbg_state;

  apb_req_arbiter #(.WIDTH(8)) dut (
    .i_PCLK(i_PCLK), .i_PRESETn(i_PRESETn), .i_req(i_req),
    .i_rw0(i_rw0), .i_rw1(i_rw1), .i_addr0(i_addr0), .i_addr1(i_addr1),
    .i_wdata0(i_wdata0), .i_wdata1(i_wdata1), .o_gnt(o_gnt), .o_done(o_done),
    .o_rdata(o_rdata), .o_busy(o_busy), .o_transfer(o_transfer),
    .o_READ_WRITE(o_READ_WRITE), .o_apb_write_paddr(o_apb_write_paddr),
    .o_apb_read_paddr(o_apb_read_paddr), .o_apb_write_data(o_apb_write_data),
    .i_PSEL1(i_PSEL1), .i_PENABLE(i_PENABLE), .i_PREADY(i_PREADY),
    .i_prdata(i_prdata), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 i_PCLK = ~i_PCLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- APB master + slave model ----------------
  int         m_st = 0;  // 0 idle, 1 setup, 2 access
  int         wl = 0;
  int         cur_waits = 0;
  logic       m_write;
  logic [7:0] m_addr, m_wdata;
  logic [7:0] mem [256];

  // ---------------- reference model / scoreboard ----------------
  logic [16:0] exp_q[$];  // {rw, addr, wdata} per granted command
  logic        busy_m;
  logic [1:0]  mdl_gnt, mdl_done;
  int          mdl_last;
  logic        mdl_issue, mdl_rw;
  logic [7:0]  mdl_addr, mdl_wdata, mdl_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_bus();
    i_PSEL1   = (m_st != 0);
    i_PENABLE = (m_st == 2);
    i_PREADY  = (m_st == 2) && (wl == 0);
    i_prdata  = (m_st == 2) ? mem[m_addr] : 8'($urandom_range(0, 255));
  endtask

  task automatic model_reset();
    exp_q.delete();
    busy_m = 0; mdl_gnt = 0; mdl_done = 0; mdl_last = 1; mdl_issue = 0;
    mdl_rw = 0; mdl_addr = 0; mdl_wdata = 0; mdl_rdata = 0;
    m_st = 0; wl = 0; m_write = 0; m_addr = 0; m_wdata = 0;
    drive_bus();
  endtask

  task automatic check_all_outputs();
    check("gnt", o_gnt, mdl_gnt);
    check("done", o_done, mdl_done);
    check("transfer", o_transfer, mdl_issue);
    check("busy", o_busy, busy_m);
    check("rdata", o_rdata, mdl_rdata);
    check("rw_out", o_READ_WRITE, mdl_rw);
    check("wpaddr", o_apb_write_paddr, mdl_addr);
    check("rpaddr", o_apb_read_paddr, mdl_addr);
    check("wdata_out", o_apb_write_data, mdl_wdata);
  endtask

  // One clock: called at a negedge, returns at the next negedge.
  task automatic step();
    logic       tr, acc, p_rw;
    logic [7:0] p_wa, p_ra, p_wd, p_prd;
    logic [1:0] req_pre, done_pre, nd;
    logic       r_rw[2];
    logic [7:0] r_a[2], r_d[2];
    logic [16:0] item;
    int         w;
    tr = o_transfer; acc = i_PSEL1 & i_PENABLE & i_PREADY;
    p_rw = o_READ_WRITE; p_wa = o_apb_write_paddr; p_ra = o_apb_read_paddr;
    p_wd = o_apb_write_data; p_prd = i_prdata;
    req_pre = i_req; done_pre = mdl_done;
    r_rw[0] = i_rw0; r_a[0] = i_addr0; r_d[0] = i_wdata0;
    r_rw[1] = i_rw1; r_a[1] = i_addr1; r_d[1] = i_wdata1;
    @(posedge i_PCLK);
    #1;
    if (acc && m_write) mem[m_addr] = m_wdata;
    case (m_st)
      0: if (tr) begin
        m_st = 1; m_write = p_rw; m_addr = p_rw ? p_wa : p_ra; m_wdata = p_wd;
        check("rd_wr_paddr_agree", p_wa, p_ra);
        if (exp_q.size() == 0) check("spurious_transfer", 1, 0);
        else begin
          item = exp_q.pop_front();
          check("bus_cmd", {m_write, m_addr, m_wdata}, item);
        end
      end
      1: begin m_st = 2; wl = cur_waits; end
      default: if (acc) m_st = 0; else if (wl > 0) wl--;
    endcase
    drive_bus();
    nd = 2'b00;
    mdl_issue = 0;
    if (busy_m && done_pre != 0) begin
      busy_m = 0; mdl_gnt = 0;
    end else if (busy_m && acc) begin
      nd = mdl_gnt;
      mdl_last = mdl_gnt[1] ? 1 : 0;
      if (!mdl_rw) mdl_rdata = p_prd;
    end else if (!busy_m && req_pre != 0) begin
      if (req_pre == 2'b11) w = 1 - mdl_last;
      else w = req_pre[1] ? 1 : 0;
      busy_m = 1; mdl_issue = 1;
      mdl_gnt = (w == 1) ? 2'b10 : 2'b01;
      mdl_rw = r_rw[w]; mdl_addr = r_a[w]; mdl_wdata = r_d[w];
      exp_q.push_back({mdl_rw, mdl_addr, mdl_wdata});
    end
    mdl_done = nd;
    @(negedge i_PCLK);
    cyc++;
    check_all_outputs();
  endtask

  task automatic set_fields(input int n, input logic rw, input logic [7:0] a, input logic [7:0] d);
    if (n == 0) begin i_rw0 = rw; i_addr0 = a; i_wdata0 = d; end
    else begin i_rw1 = rw; i_addr1 = a; i_wdata1 = d; end
  endtask

  task automatic do_reset();
    i_PRESETn = 1'b0;
    i_req = 2'b00;
    model_reset();
    repeat (2) @(negedge i_PCLK);
    i_PRESETn = 1'b1;
    check_all_outputs();
    check("reset_state", o_dbg_state, 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0] req;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       preload;
    logic [7:0] slave;
    int         waits;
    int         done_at;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[6];
  int   order[4];

  initial begin
    int got, n;
    i_rw0 = 0; i_rw1 = 0; i_addr0 = 0; i_addr1 = 0; i_wdata0 = 0; i_wdata1 = 0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 255));
    vecs[0] = '{2'b01, 1'b1, 8'h12, 8'hA5, 1'b0, 8'h00, 0, 4, 8'h00};
    vecs[1] = '{2'b10, 1'b0, 8'h30, 8'h00, 1'b1, 8'h5C, 2, 6, 8'h5C};
    vecs[2] = '{2'b01, 1'b0, 8'h40, 8'h00, 1'b1, 8'h77, 0, 4, 8'h77};
    vecs[3] = '{2'b10, 1'b1, 8'h41, 8'h99, 1'b0, 8'h00, 1, 5, 8'h77};
    vecs[4] = '{2'b01, 1'b0, 8'h12, 8'h00, 1'b0, 8'h00, 3, 7, 8'hA5};
    vecs[5] = '{2'b10, 1'b0, 8'h41, 8'h00, 1'b0, 8'h00, 0, 4, 8'h99};
    order = '{0, 1, 0, 1};

    do_reset();
    step();

    for (int v = 0; v < 6; v++) begin
      n = vecs[v].req[1] ? 1 : 0;
      set_fields(n, vecs[v].rw, vecs[v].addr, vecs[v].wdata);
      if (vecs[v].preload) mem[vecs[v].addr] = vecs[v].slave;
      cur_waits = vecs[v].waits;
      i_req = vecs[v].req;
      got = -1;
      for (int k = 1; k <= 40 && got < 0; k++) begin
        step();
        if (k == 1) check("v_transfer_c1", o_transfer, 1);
        if (k == 2) check("v_transfer_c2", o_transfer, 0);
        set_fields(n, ~vecs[v].rw, ~vecs[v].addr, ~vecs[v].wdata);
        if (o_done != 0) begin
          got = k;
          check("v_done_mask", o_done, vecs[v].req);
          check("v_done_cycle", k, vecs[v].done_at);
          check("v_rdata", o_rdata, vecs[v].rdata);
          check("v_bus_addr", m_addr, vecs[v].addr);
          check("v_held_addr", o_apb_read_paddr, vecs[v].addr);
          if (vecs[v].rw) check("v_slave_mem", mem[vecs[v].addr], vecs[v].wdata);
          i_req = 2'b00;
        end else begin
          check("v_gnt_inflight", o_gnt, vecs[v].req);
        end
      end
      if (got < 0) begin check("v_timeout", 0, 1); i_req = 2'b00; end
      step();
      check("v_idle_after", o_busy, 0);
    end

    // contention from reset: service must alternate 0,1,0,1
    do_reset();
    set_fields(0, 1'b1, 8'h10, 8'h01);
    set_fields(1, 1'b1, 8'h20, 8'h02);
    cur_waits = 0;
    i_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      got = -1;
      for (int k = 0; k < 30 && got < 0; k++) begin
        step();
        if (o_done != 0) got = o_done[1] ? 1 : 0;
      end
      if (got < 0) begin check("c_timeout", 0, 1); break; end
      check("c_order", got, order[t]);
      check("c_addr", m_addr, (order[t] == 1) ? 8'h20 : 8'h10);
      if (t == 3) i_req = 2'b00;
      else begin
        i_req[got] = 1'b0;
        step();
        i_req[got] = 1'b1;
      end
    end
    repeat (3) step();

    // reset while waiting on the slave
    set_fields(0, 1'b1, 8'h50, 8'h3C);
    cur_waits = 6;
    i_req = 2'b01;
    repeat (4) step();
    check("r_busy_before", o_busy, 1);
    i_PRESETn = 1'b0;
    #1;
    check("r_gnt", o_gnt, 0);
    check("r_done", o_done, 0);
    check("r_busy", o_busy, 0);
    check("r_transfer", o_transfer, 0);
    check("r_rw", o_READ_WRITE, 0);
    check("r_wpaddr", o_apb_write_paddr, 0);
    check("r_rpaddr", o_apb_read_paddr, 0);
    check("r_wdata", o_apb_write_data, 0);
    check("r_rdata", o_rdata, 0);
    i_req = 2'b00;
    model_reset();
    @(negedge i_PCLK);
    i_PRESETn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("r_no_done", o_done, 0);
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cur_waits = $urandom_range(0, 3);
      step();
      for (int r = 0; r < 2; r++) begin
        if (o_done[r]) i_req[r] = 1'b0;
        else if (!i_req[r] && $urandom_range(0, 2) == 0) begin
          set_fields(r, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
          i_req[r] = 1'b1;
        end else if (o_gnt[r] && $urandom_range(0, 1) == 1) begin
          set_fields(r, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
      end
    end
    got = 0;
    for (int k = 0; k < 60 && got == 0; k++) begin
      step();
      for (int r = 0; r < 2; r++) if (o_done[r]) i_req[r] = 1'b0;
      if (i_req == 2'b00 && !o_busy) got = 1;
    end
    check("drain_idle", got, 1);
    check("drain_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-requester round-robin arbiter and sequencer placed in front of the APB master. It captures one request at a time, drives the master's transfer/command inputs, and detects completion by watching the APB bus. It then returns read data and a done pulse to the winning requester. This lets two independent clients share a single APB master without bus contention.

## Interface
- WIDTH, 8, address and data width; must match the APB master's WIDTH.
- i_PCLK  in  1  APB clock; all state changes on rising edge.
- i_PRESETn  in  1  reset, asynchronous, active-low.
- i_req  in  2  request per requester, bit n = requester n.
- i_rw0, i_rw1  in  1  1 = write, 0 = read.
- i_addr0, i_addr1  in  WIDTH  target address.
- i_wdata0, i_wdata1  in  WIDTH  write data; ignored for reads.
- o_gnt  out  2  one-hot grant; bit n high while requester n's transfer is in flight.
- o_done  out  2  one-cycle completion pulse to the winning requester.
- o_rdata  out  WIDTH  read data captured at completion; holds until the next read completes.
- o_busy  out  1  high whenever the state is not IDLE.
- o_transfer  out  1  to the APB master's i_transfer.
- o_READ_WRITE  out  1  to the APB master's i_READ_WRITE.
- o_apb_write_paddr, o_apb_read_paddr  out  WIDTH  both carry the latched address.
- o_apb_write_data  out  WIDTH  latched write data.
- i_PSEL1, i_PENABLE, i_PREADY  in  1  APB bus observation.
- i_prdata  in  WIDTH  APB read data.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If i_req == 0, stay in IDLE.
  - Otherwise select a winner, latch its rw, addr and wdata into internal registers, set o_gnt, and go to ISSUE.
- Arbitration:
  - A single requester wins outright.
  - If both request, the winner is the requester not recorded in the last_served pointer.
  - last_served updates to the winner on entry to DONE.
  - last_served resets to 1, so requester 0 wins the first contended arbitration.
- ISSUE: o_transfer = 1 for exactly this cycle; go to WAIT unconditionally.
- WAIT:
  - o_transfer = 0.
  - Completion is the cycle where i_PSEL1 & i_PENABLE & i_PREADY is true.
  - On completion: for a read, capture i_prdata into o_rdata; go to DONE.
  - Otherwise stay in WAIT; wait states are unbounded.
- DONE: o_done[winner] = 1; clear o_gnt at the exit edge; go to IDLE.
- Command outputs (o_READ_WRITE, addresses, o_apb_write_data) are driven from the latched registers, not the live requester inputs. They stay stable from ISSUE through DONE.
- Requester contract:
  - Hold i_req[n] high until o_done[n] is seen; drop it at the same edge that ends DONE.
  - The rw/addr/wdata fields need to be valid only during the IDLE cycle in which the grant is taken.
  - i_req is sampled only in IDLE; requests arriving mid-transfer wait.
- Writes leave o_rdata unchanged.

## Timing
- Reset (asynchronous, any state): state = IDLE; o_gnt, o_done, o_busy, o_transfer and o_READ_WRITE = 0; address/data outputs = 0; o_rdata = 0; last_served = 1. An in-flight transfer is abandoned, and requesters must re-request.
- Zero-wait transfer, with request seen in IDLE at cycle c0:
  - ISSUE at c1 (o_transfer high; master sees it).
  - WAIT at c2, while the master is in SETUP.
  - WAIT at c3, while the master is in ACCESS with PREADY = 1.
  - DONE at c4, with o_done high.
  - IDLE at c5.
- Each slave wait state adds one cycle.
- Back-to-back transfers: a request pending in the IDLE cycle after DONE is granted immediately. The minimum spacing between o_done pulses is 5 cycles.
- o_transfer is never high in WAIT. The master therefore returns to its idle state after each ACCESS and never chains into SETUP.
- o_gnt is one-hot or zero at all times. o_done is never high for the non-granted requester.

## Test plan
- Reset, then single write: req0 with addr 0x12, wdata 0xA5, PREADY tied to 1 → o_transfer is high for one cycle at c1; the master drives paddr 0x12 / pwdata 0xA5; o_done = 2'b01 at c4.
- Single read with 2 wait states: req1 with addr 0x30; the slave returns 0x5C with PREADY low for 2 ACCESS cycles → o_done = 2'b10 at c6, o_rdata = 0x5C, and o_gnt = 2'b10 throughout.
- Contention: both requesters assert from reset → the order of service is 0, 1, 0, 1 across four transfers, each using its own latched address.
- Input change mid-transfer: change i_addr0 to 0xFF during WAIT → the bus address stays at the latched value.
- Reset asserted during WAIT → all outputs go to 0 immediately; after release, o_done does not pulse until a new request is made.
- Write after read: a read returns 0x77, then a write completes → o_rdata stays 0x77.
